// File: rtl/tc_ram_copier.sv
// Word-by-word RAM-to-RAM copier: READ/WRITE ping-pong at 2 cycles per word.
// Define TC_RAM_COPIER_FILL_EN to add a constant-fill mode at 1 cycle per word.
module tc_ram_copier #(
  parameter int unsigned UUID      = 0,
  parameter              NAME      = "",
  parameter int unsigned BIT_WIDTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        fill_mode,
  input  logic [15:0] src_addr,
  input  logic [15:0] dst_addr,
  input  logic [15:0] length,
  input  logic [63:0] fill_value,
  output logic        ram_load,
  output logic        ram_save,
  output logic [15:0] ram_address,
  output logic [63:0] ram_wdata,
  input  logic [63:0] ram_rdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] count
);

`ifdef TC_RAM_COPIER_FILL_EN
  localparam bit FillEn = 1'b1;
`else
  localparam bit FillEn = 1'b0;
`endif

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e               state_q, state_d;
  logic [15:0]          src_q, dst_q, remaining_q, count_q;
  logic [BIT_WIDTH-1:0] data_q;
  logic                 fill_q;

  // Parameters are labels only; upper read-data bits and the fill inputs may go unused.
  logic unused_inputs;
  assign unused_inputs = ^{UUID, NAME, fill_mode, fill_value, ram_rdata};

  assign count = count_q;

  always_comb begin
    state_d     = state_q;
    ram_load    = 1'b0;
    ram_save    = 1'b0;
    ram_address = '0;
    ram_wdata   = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (length == 16'd0)         state_d = StDone;
          else if (FillEn && fill_mode) state_d = StWrite;
          else                          state_d = StRead;
        end
      end
      StRead: begin
        ram_load    = 1'b1;
        ram_address = src_q;
        busy        = 1'b1;
        state_d     = abort ? StDone : StWrite;
      end
      StWrite: begin
        ram_save    = 1'b1;
        ram_address = dst_q;
        busy        = 1'b1;
        ram_wdata[BIT_WIDTH-1:0] = fill_q ? fill_value[BIT_WIDTH-1:0] : data_q;
        // An abort here still lets the current word land before stopping.
        if (remaining_q == 16'd1 || abort) state_d = StDone;
        else if (fill_q)                  state_d = StWrite;
        else                              state_d = StRead;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      src_q       <= '0;
      dst_q       <= '0;
      remaining_q <= '0;
      count_q     <= '0;
      data_q      <= '0;
      fill_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        StIdle: begin
          if (start) begin
            src_q       <= src_addr;
            dst_q       <= dst_addr;
            remaining_q <= length;
            count_q     <= '0;
            fill_q      <= FillEn & fill_mode;
          end
        end
        StRead: data_q <= ram_rdata[BIT_WIDTH-1:0];
        StWrite: begin
          src_q       <= src_q + 16'd1;
          dst_q       <= dst_q + 16'd1;
          count_q     <= count_q + 16'd1;
          remaining_q <= remaining_q - 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tc_ram_copier.sv
// Scoreboard bench for tc_ram_copier: a driver pushes expected reads, writes and done
// events computed from a shadow memory; a negedge monitor pops and compares them.
module tb_tc_ram_copier;
  localparam int unsigned BW = 16;

  logic        clk = 1'b0;
  logic        rst, start, abort, fill_mode;
  logic [15:0] src_addr, dst_addr, length;
  logic [63:0] fill_value;
  logic        ram_load, ram_save, busy, done;
  logic [15:0] ram_address, count;
  logic [63:0] ram_wdata, ram_rdata;

  tc_ram_copier #(.UUID(7), .NAME("cp"), .BIT_WIDTH(BW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .fill_mode(fill_mode),
    .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_value(fill_value),
    .ram_load(ram_load), .ram_save(ram_save), .ram_address(ram_address),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] init_word(input logic [15:0] a);
    return {16'hC0DE ^ a, a * 16'd7, ~a, a + 16'h1234};
  endfunction

  function automatic logic [63:0] trunc(input logic [63:0] v);
    if (BW >= 64) return v;
    return v & ((64'd1 << BW) - 64'd1);
  endfunction

  // RAM environment: combinational read, commit on falling edge.
  logic [63:0] ram_m [0:65535];
  bit          ram_v [0:65535];
  assign ram_rdata = ram_v[ram_address] ? ram_m[ram_address] : init_word(ram_address);
  always @(negedge clk) begin
    if (ram_save) begin
      ram_m[ram_address] <= ram_wdata;
      ram_v[ram_address] <= 1'b1;
    end
  end

  // Reference shadow memory, touched only by the driver.
  logic [63:0] sh_m [0:65535];
  bit          sh_v [0:65535];
  function automatic logic [63:0] sh_rd(input logic [15:0] a);
    return sh_v[a] ? sh_m[a] : init_word(a);
  endfunction

  logic [15:0] rq[$];
  logic [79:0] wq[$];
  int          dq_cyc[$];
  int          dq_cnt[$];

  // Monitor: pop and compare whenever the DUT presents an event.
  always @(negedge clk) begin
    if (!rst) begin
      chk("busy_vs_strobe", {63'd0, busy}, {63'd0, ram_load | ram_save});
      if (!busy) begin
        chk("idle_addr", {48'd0, ram_address}, 64'd0);
        chk("idle_wdata", ram_wdata, 64'd0);
      end
      if (ram_load) begin
        if (rq.size() == 0) chk("rd_unexpected", {63'd0, ram_load}, 64'd0);
        else chk("rd_addr", {48'd0, ram_address}, {48'd0, rq.pop_front()});
      end
      if (ram_save) begin
        if (wq.size() == 0) chk("wr_unexpected", {63'd0, ram_save}, 64'd0);
        else begin
          logic [79:0] w;
          w = wq.pop_front();
          chk("wr_addr", {48'd0, ram_address}, {48'd0, w[79:64]});
          chk("wr_data", ram_wdata, w[63:0]);
        end
      end
      if (done) begin
        if (dq_cyc.size() == 0) chk("done_unexpected", {63'd0, done}, 64'd0);
        else begin
          chk("done_cycle", 64'(cyc), 64'(dq_cyc.pop_front()));
          chk("done_count", {48'd0, count}, 64'(dq_cnt.pop_front()));
          chk("done_busy", {63'd0, busy}, 64'd0);
        end
      end
    end
  end

  // One transfer. ab_sel: 0 none, 1 abort in READ of word ab_k, 2 abort in WRITE of word ab_k.
  task automatic run_xfer(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                          input int ab_sel, input int ab_k, input logic fm,
                          input logic [63:0] fv);
    bit fill;
    int dly, abe, words, reads, sel;
    logic [63:0] val;
    logic [15:0] a;
`ifdef TC_RAM_COPIER_FILL_EN
    fill = fm;
`else
    fill = 1'b0;
`endif
    sel = ab_sel;
    if (n == 16'd0 || ab_k >= int'(n) || sel > 2) sel = 0;
    if (fill && sel == 1) sel = 2;
    abe = -1;
    if (n == 16'd0) begin
      dly = 0; words = 0; reads = 0;
    end else if (fill) begin
      reads = 0;
      if (sel == 0) begin words = int'(n); dly = int'(n); end
      else begin words = ab_k + 1; dly = ab_k + 1; abe = dly; end
    end else if (sel == 0) begin
      words = int'(n); reads = int'(n); dly = 2 * int'(n);
    end else if (sel == 1) begin
      words = ab_k; reads = ab_k + 1; dly = 2 * ab_k + 1; abe = dly;
    end else begin
      words = ab_k + 1; reads = ab_k + 1; dly = 2 * ab_k + 2; abe = dly;
    end
    // Ascending one-word-at-a-time copy: overlapping ranges propagate forward.
    for (int i = 0; i < reads; i++) rq.push_back(s + 16'(i));
    for (int i = 0; i < words; i++) begin
      a   = d + 16'(i);
      val = trunc(fill ? fv : sh_rd(s + 16'(i)));
      sh_m[a] = val;
      sh_v[a] = 1'b1;
      wq.push_back({a, val});
    end
    for (int e = 0; e <= dly + 2; e++) begin
      @(negedge clk);
      if (e == 0) begin
        src_addr = s; dst_addr = d; length = n; fill_mode = fm; fill_value = fv;
        start = 1'b1;
        dq_cyc.push_back(cyc + 1 + dly);
        dq_cnt.push_back(words);
      end else if (e == 1) begin
        // Second start while already running must be ignored.
        src_addr = 16'($urandom); dst_addr = 16'($urandom); length = 16'($urandom);
        fill_mode = 1'($urandom);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (e == abe) abort = 1'b1;
      else if (e == 0 || e == dly + 1) abort = 1'($urandom);
      else abort = 1'b0;
    end
    @(negedge clk);
    abort = 1'b0;
    chk("idle_count_hold", {48'd0, count}, 64'(words));
    chk("rd_left", 64'(rq.size()), 64'd0);
    chk("wr_left", 64'(wq.size()), 64'd0);
    chk("done_left", 64'(dq_cyc.size()), 64'd0);
    rq.delete(); wq.delete(); dq_cyc.delete(); dq_cnt.delete();
  endtask

  initial begin
    logic [15:0] s, d, n;
    rst = 1'b1; start = 1'b0; abort = 1'b0; fill_mode = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_count", {48'd0, count}, 64'd0);
    chk("rst_strobes", {62'd0, ram_load, ram_save}, 64'd0);
    chk("rst_addr", {48'd0, ram_address}, 64'd0);
    chk("rst_wdata", ram_wdata, 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    run_xfer(16'h0010, 16'h0040, 16'd4, 0, 0, 1'b0, 64'd0);
    run_xfer(16'h0123, 16'h0456, 16'd0, 0, 0, 1'b0, 64'd0);
    run_xfer(16'hFFFF, 16'h0100, 16'd2, 0, 0, 1'b0, 64'd0);
    run_xfer(16'h0200, 16'h0300, 16'd5, 1, 1, 1'b0, 64'd0);
    run_xfer(16'h0400, 16'h0401, 16'd6, 0, 0, 1'b0, 64'd0);
    run_xfer(16'h0500, 16'h0020, 16'd3, 0, 0, 1'b1, 64'hBEEF);
    run_xfer(16'h0600, 16'h0610, 16'd3, 2, 2, 1'b0, 64'd0);
    run_xfer(16'h0620, 16'h0630, 16'd4, 2, 1, 1'b1, 64'h1234_5678_9ABC_DEF0);

    for (int t = 0; t < 40; t++) begin
      s = ($urandom_range(0, 3) == 0) ? 16'hFFF8 + 16'($urandom_range(0, 7))
                                      : 16'($urandom_range(0, 255));
      d = ($urandom_range(0, 1) == 0) ? s + 16'($urandom_range(0, 4)) - 16'd2
                                      : 16'($urandom_range(0, 255));
      n = 16'($urandom_range(0, 8));
      run_xfer(s, d, n, $urandom_range(0, 3), $urandom_range(0, 8), 1'($urandom),
               {$urandom, $urandom});
    end

    // Asynchronous reset landing inside the second WRITE, before its falling edge.
    @(negedge clk);
    src_addr = 16'h0700; dst_addr = 16'h0800; length = 16'd5; fill_mode = 1'b0;
    start = 1'b1;
    rq.push_back(16'h0700);
    rq.push_back(16'h0701);
    wq.push_back({16'h0800, trunc(sh_rd(16'h0700))});
    sh_m[16'h0800] = trunc(sh_rd(16'h0700));
    sh_v[16'h0800] = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_save", {63'd0, ram_save}, 64'd1);
    chk("pre_rst_count", {48'd0, count}, 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_save", {63'd0, ram_save}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_count", {48'd0, count}, 64'd0);
    chk("arst_addr", {48'd0, ram_address}, 64'd0);
    chk("arst_wdata", ram_wdata, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    chk("post_rst_rd_left", 64'(rq.size()), 64'd0);
    chk("post_rst_wr_left", 64'(wq.size()), 64'd0);
    rq.delete(); wq.delete();
    run_xfer(16'h0800, 16'h0900, 16'd3, 0, 0, 1'b0, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
